// File: rtl/riscv_pkg.sv
// Shared RV32I core definitions: default datapath sizes, register-file state
// encoding and the address-width helper.
package riscv_pkg;

  localparam int XLEN_DEFAULT  = 32;
  localparam int NREGS_DEFAULT = 32;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } rf_state_e;

  // Ceiling log2 with a floor of 1 so a two-entry file still gets an address bit.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/register_file_if.sv
// Read/write/clear bus between the decode/writeback stages and the register file.
interface register_file_if #(
  parameter int XLEN  = 32,
  parameter int NREAD = 2,
  parameter int ADDRW = 5
);
  logic [NREAD-1:0]       readEnable;
  logic [NREAD*ADDRW-1:0] readAddr;
  logic [NREAD*XLEN-1:0]  readData;
  logic                   writeEnable;
  logic [ADDRW-1:0]       writeAddr;
  logic [XLEN-1:0]        writeData;
  logic                   clearRequest;
  logic                   busy;

  modport master (
    output readEnable, readAddr, writeEnable, writeAddr, writeData, clearRequest,
    input  readData, busy
  );

  modport slave (
    input  readEnable, readAddr, writeEnable, writeAddr, writeData, clearRequest,
    output readData, busy
  );
endinterface

// File: rtl/register_read_port.sv
// One registered read port: address masking, write-to-read forwarding and
// an output register that holds between enabled reads.
module register_read_port #(
  parameter int XLEN          = 32,
  parameter int NREGS         = 32,
  parameter int ADDRW         = 5,
  parameter bit BYPASS        = 1'b1,
  parameter bit HARDWIRE_ZERO = 1'b1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             flush,
  input  logic             read_en,
  input  logic [ADDRW-1:0] read_addr,
  input  logic [XLEN-1:0]  array_word,
  input  logic             wr_fire,
  input  logic [ADDRW-1:0] wr_addr,
  input  logic [XLEN-1:0]  wr_data,
  output logic [XLEN-1:0]  read_data
);

  localparam logic [ADDRW:0] LIMIT = (ADDRW+1)'(NREGS);

  logic addr_ok;
  logic fwd_hit;
  logic [XLEN-1:0] read_value;

  // wr_fire already excludes dropped writes, so a forwarded value is always one
  // that really lands in the array.
  assign addr_ok = ({1'b0, read_addr} < LIMIT) && !(HARDWIRE_ZERO && read_addr == '0);
  assign fwd_hit = BYPASS && wr_fire && (wr_addr == read_addr);

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    read_value = '0;
    if (addr_ok) read_value = fwd_hit ? wr_data : array_word;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)       read_data <= '0;
    else if (flush)   read_data <= '0;
    else if (read_en) read_data <= read_value;
  end

endmodule

// File: rtl/register_file.sv
// Integer register bank: storage array, write path, clear sequencer and
// NREAD independent registered read ports.
module register_file
  import riscv_pkg::*;
#(
  parameter int XLEN          = XLEN_DEFAULT,
  parameter int NREGS         = NREGS_DEFAULT,
  parameter int NREAD         = 2,
  parameter bit BYPASS        = 1'b1,
  parameter bit HARDWIRE_ZERO = 1'b1
) (
  input logic            CLK,
  input logic            RESET,
  register_file_if.slave rf
);

  localparam int ADDRW = clog2(NREGS);
  localparam logic [ADDRW:0]   LIMIT    = (ADDRW+1)'(NREGS);
  localparam logic [ADDRW-1:0] LAST_IDX = ADDRW'(NREGS - 1);

  rf_state_e        state, next_state;
  logic [ADDRW-1:0] clear_index, next_index;
  logic             busy_q, next_busy;

  logic [XLEN-1:0]  mem [NREGS];
  logic             wr_fire;
  logic             flush;

  // ---------------- clear sequencer ----------------
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state       <= CLEAR;
      clear_index <= '0;
      busy_q      <= 1'b1;
    end else begin
      state       <= next_state;
      clear_index <= next_index;
      busy_q      <= next_busy;
    end
  end

  always_comb begin
    next_state = state;
    next_index = clear_index;
    next_busy  = busy_q;
    unique case (state)
      CLEAR: begin
        next_index = clear_index + 1'b1;
        next_busy  = 1'b1;
        if (clear_index == LAST_IDX) begin
          next_state = READY;
          next_index = '0;
          next_busy  = 1'b0;
        end
      end
      READY: begin
        next_busy = 1'b0;
        if (rf.clearRequest) begin
          next_state = CLEAR;
          next_index = '0;
          next_busy  = 1'b1;
        end
      end
      default: begin
        next_state = CLEAR;
        next_index = '0;
        next_busy  = 1'b1;
      end
    endcase
  end

  assign rf.busy = busy_q;

  // ---------------- write path ----------------
  assign wr_fire = (state == READY) && !rf.clearRequest && rf.writeEnable &&
                   ({1'b0, rf.writeAddr} < LIMIT) &&
                   !(HARDWIRE_ZERO && rf.writeAddr == '0);

  // Reads return 0 while clearing and on the cycle a clear is requested.
  assign flush = (state != READY) || rf.clearRequest;

  // NOTE: the array has no reset; the clear sequencer zeroes it, which keeps it mappable to RAM.
  // Gating on RESET stops a write from landing on an edge while reset is held.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      if (state == CLEAR) mem[clear_index] <= '0;
      else if (wr_fire)   mem[rf.writeAddr] <= rf.writeData;
    end
  end

  // ---------------- read ports ----------------
  for (genvar p = 0; p < NREAD; p++) begin : g_port
    logic [ADDRW-1:0] port_addr;
    logic [ADDRW-1:0] safe_addr;
    logic [XLEN-1:0]  port_data;

    assign port_addr = rf.readAddr[p*ADDRW +: ADDRW];
    // Out-of-range addresses are masked in the port; clamp so the array index stays legal.
    assign safe_addr = ({1'b0, port_addr} < LIMIT) ? port_addr : '0;

    register_read_port #(
      .XLEN          (XLEN),
      .NREGS         (NREGS),
      .ADDRW         (ADDRW),
      .BYPASS        (BYPASS),
      .HARDWIRE_ZERO (HARDWIRE_ZERO)
    ) u_port (
      .CLK        (CLK),
      .RESET      (RESET),
      .flush      (flush),
      .read_en    (rf.readEnable[p]),
      .read_addr  (port_addr),
      .array_word (mem[safe_addr]),
      .wr_fire    (wr_fire),
      .wr_addr    (rf.writeAddr),
      .wr_data    (rf.writeData),
      .read_data  (port_data)
    );

    assign rf.readData[p*XLEN +: XLEN] = port_data;
  end

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: default configuration, a no-bypass copy
// and a 24-entry three-port copy, all sharing one clock and reset.
module tb_register_file;
  import riscv_pkg::*;

  logic CLK = 1'b0;
  logic RESET;
  int   errors = 0;
  int   checks = 0;

  always #5 CLK = ~CLK;

  register_file_if #(.XLEN(32), .NREAD(2), .ADDRW(5)) ifd ();
  register_file_if #(.XLEN(32), .NREAD(2), .ADDRW(5)) ifn ();
  register_file_if #(.XLEN(32), .NREAD(3), .ADDRW(5)) ifs ();

  register_file #(.XLEN(32), .NREGS(32), .NREAD(2), .BYPASS(1'b1), .HARDWIRE_ZERO(1'b1))
    u_def (.CLK(CLK), .RESET(RESET), .rf(ifd));
  register_file #(.XLEN(32), .NREGS(32), .NREAD(2), .BYPASS(1'b0), .HARDWIRE_ZERO(1'b1))
    u_nb (.CLK(CLK), .RESET(RESET), .rf(ifn));
  register_file #(.XLEN(32), .NREGS(24), .NREAD(3), .BYPASS(1'b1), .HARDWIRE_ZERO(1'b1))
    u_small (.CLK(CLK), .RESET(RESET), .rf(ifs));

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_all;
    ifd.readEnable = '0; ifd.readAddr = '0; ifd.writeEnable = 1'b0;
    ifd.writeAddr = '0; ifd.writeData = '0; ifd.clearRequest = 1'b0;
    ifn.readEnable = '0; ifn.readAddr = '0; ifn.writeEnable = 1'b0;
    ifn.writeAddr = '0; ifn.writeData = '0; ifn.clearRequest = 1'b0;
    ifs.readEnable = '0; ifs.readAddr = '0; ifs.writeEnable = 1'b0;
    ifs.writeAddr = '0; ifs.writeData = '0; ifs.clearRequest = 1'b0;
  endtask

  task automatic write_def(input logic [4:0] a, input logic [31:0] d);
    ifd.writeEnable = 1'b1; ifd.writeAddr = a; ifd.writeData = d;
    tick;
    ifd.writeEnable = 1'b0;
  endtask

  task automatic read_def(input logic [4:0] a0, input logic [4:0] a1);
    ifd.readEnable = 2'b11; ifd.readAddr = {a1, a0};
    tick;
    ifd.readEnable = 2'b00;
  endtask

  // Ticks until the default instance drops busy; n is the tick count (bounded).
  task automatic wait_def(output int n);
    n = 0;
    do begin
      tick;
      n++;
    end while (ifd.busy && n < 100);
  endtask

  task automatic test_reset;
    int n_d, n_n, n_s;
    RESET = 1'b0;
    tick; tick;
    checks++; if (ifd.busy !== 1'b1) begin errors++; $display("FAIL reset_busy_def: got %b expected 1", ifd.busy); end
    checks++; if (ifs.busy !== 1'b1) begin errors++; $display("FAIL reset_busy_small: got %b expected 1", ifs.busy); end
    checks++; if (ifd.readData !== 64'd0) begin errors++; $display("FAIL reset_data_def: got %h expected 0", ifd.readData); end
    checks++; if (ifs.readData !== 96'd0) begin errors++; $display("FAIL reset_data_small: got %h expected 0", ifs.readData); end
    RESET = 1'b1;
    n_d = 0; n_n = 0; n_s = 0;
    for (int i = 1; i <= 40; i++) begin
      tick;
      if (!ifd.busy && n_d == 0) n_d = i;
      if (!ifn.busy && n_n == 0) n_n = i;
      if (!ifs.busy && n_s == 0) n_s = i;
    end
    checks++; if (n_d !== 32) begin errors++; $display("FAIL clear_len_def: got %0d expected 32", n_d); end
    checks++; if (n_n !== 32) begin errors++; $display("FAIL clear_len_nb: got %0d expected 32", n_n); end
    checks++; if (n_s !== 24) begin errors++; $display("FAIL clear_len_small: got %0d expected 24", n_s); end
  endtask

  task automatic test_preload_reset;
    int n;
    logic [4:0] a0, a1;
    for (int i = 1; i < 32; i++) write_def(5'(i), 32'hDEADBEEF);
    read_def(5'd1, 5'd31);
    checks++; if (ifd.readData !== {32'hDEADBEEF, 32'hDEADBEEF}) begin
      errors++; $display("FAIL preload_sanity: got %h expected deadbeefdeadbeef", ifd.readData); end
    RESET = 1'b0;
    tick;
    RESET = 1'b1;
    wait_def(n);
    checks++; if (n !== 32) begin errors++; $display("FAIL preload_clear_len: got %0d expected 32", n); end
    for (int i = 1; i < 32; i += 2) begin
      a0 = 5'(i);
      a1 = (i == 31) ? 5'd31 : 5'(i + 1);
      read_def(a0, a1);
      checks++; if (ifd.readData !== 64'd0) begin
        errors++; $display("FAIL preload_cleared x%0d/x%0d: got %h expected 0", a0, a1, ifd.readData); end
    end
  endtask

  task automatic test_write_read;
    write_def(5'd5, 32'h12345678);
    read_def(5'd5, 5'd5);
    checks++; if (ifd.readData[31:0] !== 32'h12345678) begin errors++; $display("FAIL wr_rd_p0: got %h expected 12345678", ifd.readData[31:0]); end
    checks++; if (ifd.readData[63:32] !== 32'h12345678) begin errors++; $display("FAIL wr_rd_p1: got %h expected 12345678", ifd.readData[63:32]); end
    // Port 0 re-reads x1 while port 1 is disabled and must hold.
    ifd.readEnable = 2'b01; ifd.readAddr = {5'd5, 5'd1};
    tick;
    ifd.readEnable = 2'b00;
    checks++; if (ifd.readData !== {32'h12345678, 32'h0}) begin errors++; $display("FAIL hold_p1: got %h expected 1234567800000000", ifd.readData); end
  endtask

  task automatic test_bypass;
    ifd.writeEnable = 1'b1; ifd.writeAddr = 5'd7; ifd.writeData = 32'hA5A5A5A5;
    ifd.readEnable = 2'b11; ifd.readAddr = {5'd7, 5'd7};
    tick;
    ifd.writeEnable = 1'b0; ifd.readEnable = 2'b00;
    checks++; if (ifd.readData !== {32'hA5A5A5A5, 32'hA5A5A5A5}) begin
      errors++; $display("FAIL bypass_def: got %h expected a5a5a5a5a5a5a5a5", ifd.readData); end
  endtask

  task automatic test_no_bypass;
    ifn.writeEnable = 1'b1; ifn.writeAddr = 5'd8; ifn.writeData = 32'h11;
    tick;
    ifn.writeEnable = 1'b0;
    ifn.readEnable = 2'b01; ifn.readAddr = {5'd0, 5'd8};
    tick;
    ifn.readEnable = 2'b00;
    checks++; if (ifn.readData[31:0] !== 32'h11) begin errors++; $display("FAIL nb_setup: got %h expected 00000011", ifn.readData[31:0]); end
    ifn.writeEnable = 1'b1; ifn.writeAddr = 5'd7; ifn.writeData = 32'hA5A5A5A5;
    ifn.readEnable = 2'b01; ifn.readAddr = {5'd0, 5'd7};
    tick;
    ifn.writeEnable = 1'b0; ifn.readEnable = 2'b00;
    checks++; if (ifn.readData[31:0] !== 32'h0) begin errors++; $display("FAIL nb_old_value: got %h expected 00000000", ifn.readData[31:0]); end
    ifn.readEnable = 2'b01;
    tick;
    ifn.readEnable = 2'b00;
    checks++; if (ifn.readData[31:0] !== 32'hA5A5A5A5) begin errors++; $display("FAIL nb_new_value: got %h expected a5a5a5a5", ifn.readData[31:0]); end
  endtask

  task automatic test_zero_reg;
    ifd.writeEnable = 1'b1; ifd.writeAddr = 5'd0; ifd.writeData = 32'hFFFFFFFF;
    ifd.readEnable = 2'b11; ifd.readAddr = {5'd5, 5'd0};
    tick;
    ifd.writeEnable = 1'b0; ifd.readEnable = 2'b00;
    checks++; if (ifd.readData !== {32'h12345678, 32'h0}) begin
      errors++; $display("FAIL x0_no_bypass: got %h expected 1234567800000000", ifd.readData); end
    read_def(5'd7, 5'd0);
    checks++; if (ifd.readData !== {32'h0, 32'hA5A5A5A5}) begin
      errors++; $display("FAIL x0_read: got %h expected 00000000a5a5a5a5", ifd.readData); end
  endtask

  task automatic test_clear_request;
    int n;
    write_def(5'd3, 32'd7);
    ifd.clearRequest = 1'b1;
    ifd.writeEnable = 1'b1; ifd.writeAddr = 5'd4; ifd.writeData = 32'd9;
    ifd.readEnable = 2'b11; ifd.readAddr = {5'd3, 5'd5};
    tick;
    ifd.clearRequest = 1'b0; ifd.writeEnable = 1'b0; ifd.readEnable = 2'b00;
    checks++; if (ifd.busy !== 1'b1) begin errors++; $display("FAIL clr_busy_rise: got %b expected 1", ifd.busy); end
    checks++; if (ifd.readData !== 64'd0) begin errors++; $display("FAIL clr_data_zero: got %h expected 0", ifd.readData); end
    n = 0;
    while (ifd.busy && n < 100) begin
      // A late restart request and a late write must both be ignored.
      ifd.clearRequest = (n == 10);
      ifd.writeEnable  = (n == 31);
      ifd.writeAddr    = 5'd9;
      ifd.writeData    = 32'h55;
      tick;
      n++;
    end
    ifd.clearRequest = 1'b0; ifd.writeEnable = 1'b0;
    checks++; if (n !== 32) begin errors++; $display("FAIL clr_len: got %0d expected 32", n); end
    read_def(5'd3, 5'd4);
    checks++; if (ifd.readData !== 64'd0) begin errors++; $display("FAIL clr_x3_x4: got %h expected 0", ifd.readData); end
    read_def(5'd9, 5'd5);
    checks++; if (ifd.readData !== 64'd0) begin errors++; $display("FAIL clr_x9_x5: got %h expected 0", ifd.readData); end
  endtask

  task automatic test_small;
    logic [4:0] addrs [4] = '{5'd30, 5'd1, 5'd2, 5'd23};
    logic [31:0] vals [4] = '{32'hCAFE0000, 32'h101, 32'h202, 32'h2323};
    for (int i = 0; i < 4; i++) begin
      ifs.writeEnable = 1'b1; ifs.writeAddr = addrs[i]; ifs.writeData = vals[i];
      tick;
    end
    ifs.writeEnable = 1'b0;
    ifs.readEnable = 3'b111; ifs.readAddr = {5'd23, 5'd2, 5'd1};
    tick;
    ifs.readEnable = 3'b000;
    checks++; if (ifs.readData !== {32'h2323, 32'h202, 32'h101}) begin
      errors++; $display("FAIL small_three_ports: got %h expected 000023230000020200000101", ifs.readData); end
    ifs.readEnable = 3'b001; ifs.readAddr = {5'd23, 5'd2, 5'd30};
    tick;
    ifs.readEnable = 3'b000;
    checks++; if (ifs.readData !== {32'h2323, 32'h202, 32'h0}) begin
      errors++; $display("FAIL small_oob_read: got %h expected 000023230000020200000000", ifs.readData); end
    // Same-cycle write and read of an out-of-range address: neither lands.
    ifs.writeEnable = 1'b1; ifs.writeAddr = 5'd30; ifs.writeData = 32'h77;
    ifs.readEnable = 3'b010; ifs.readAddr = {5'd0, 5'd30, 5'd0};
    tick;
    ifs.writeEnable = 1'b0; ifs.readEnable = 3'b000;
    checks++; if (ifs.readData[63:32] !== 32'h0) begin
      errors++; $display("FAIL small_oob_bypass: got %h expected 00000000", ifs.readData[63:32]); end
  endtask

  task automatic test_reset_mid_clear;
    int n;
    ifd.clearRequest = 1'b1;
    tick;
    ifd.clearRequest = 1'b0;
    for (int i = 0; i < 5; i++) tick;
    RESET = 1'b0;
    #2;
    checks++; if (ifd.busy !== 1'b1) begin errors++; $display("FAIL mid_reset_busy: got %b expected 1", ifd.busy); end
    tick;
    RESET = 1'b1;
    wait_def(n);
    checks++; if (n !== 32) begin errors++; $display("FAIL mid_reset_len: got %0d expected 32", n); end
  endtask

  initial begin
    idle_all();
    test_reset();
    test_preload_reset();
    test_write_read();
    test_bypass();
    test_no_bypass();
    test_zero_reg();
    test_clear_request();
    test_small();
    test_reset_mid_clear();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
